// File: rtl/ssi_read_scheduler.sv
// SSI read scheduler: sequences one-hot read starts over the enabled channels once per period,
// with CRC retry, per-read timeout and sticky failure flags. Optional stats: SSI_SCHED_STATS_EN.
module ssi_read_scheduler #(
  parameter int NUM_CH      = 3,
  parameter int READ_PERIOD = 1000,
  parameter int TIMEOUT     = 4096,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk_100m,
  input  logic              rst_syn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              fail_clr,
  input  logic [NUM_CH-1:0] rd_done,
  input  logic [NUM_CH-1:0] rd_crc_err,
  output logic [NUM_CH-1:0] rd_start,
  output logic              busy,
  output logic              scan_done,
  output logic [NUM_CH-1:0] ch_fail,
  output logic              overrun,
  output logic [7:0]        retry_cnt,
  output logic [7:0]        timeout_cnt
);
  localparam int PW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [NUM_CH-1:0] ONE    = NUM_CH'(1);
  localparam logic [PW-1:0]     P_LAST = PW'(READ_PERIOD - 1);
  localparam logic [TW-1:0]     T_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]        RMAX   = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, NEXT} state_t;

  state_t            state;
  logic [PW-1:0]     pcnt;
  logic [TW-1:0]     tcnt;
  logic [3:0]        retries;
  logic [NUM_CH-1:0] mask_q, cur_oh;
  logic [NUM_CH-1:0] low_oh, above, next_oh, fail_base;
  logic              tick, sel_done, sel_err, can_retry, tmo_hit;

  always_comb begin
    tick      = (pcnt == P_LAST);
    low_oh    = ch_mask & (~ch_mask + ONE);
    above     = mask_q & ~(cur_oh | (cur_oh - ONE));
    next_oh   = above & (~above + ONE);
    sel_done  = |(rd_done & cur_oh);
    sel_err   = |(rd_crc_err & cur_oh);
    can_retry = (retries < RMAX);
    tmo_hit   = (tcnt == T_LAST);
    fail_base = fail_clr ? '0 : ch_fail;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) pcnt <= '0;
    else         pcnt <= tick ? '0 : pcnt + PW'(1);
  end

  // Flag sets are written after the fail_clr default so a same-cycle set wins.
  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      state     <= IDLE;
      mask_q    <= '0;
      cur_oh    <= '0;
      rd_start  <= '0;
      scan_done <= 1'b0;
      ch_fail   <= '0;
      overrun   <= 1'b0;
      tcnt      <= '0;
      retries   <= '0;
    end else begin
      rd_start  <= '0;
      scan_done <= 1'b0;
      ch_fail   <= fail_base;
      overrun   <= (overrun & ~fail_clr) | (tick & (state != IDLE));
      case (state)
        IDLE: if (tick && enable && (ch_mask != '0)) begin
          mask_q   <= ch_mask;
          cur_oh   <= low_oh;
          rd_start <= low_oh;
          tcnt     <= '0;
          retries  <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          tcnt  <= tcnt + TW'(1);
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (sel_done) begin
            if (!sel_err) begin
              retries <= '0;
              state   <= NEXT;
            end else if (can_retry) begin
              retries  <= retries + 4'd1;
              rd_start <= cur_oh;
              tcnt     <= '0;
              state    <= ISSUE;
            end else begin
              ch_fail <= fail_base | cur_oh;
              retries <= '0;
              state   <= NEXT;
            end
          end else if (tmo_hit) begin
            ch_fail <= fail_base | cur_oh;
            retries <= '0;
            state   <= NEXT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        NEXT: begin
          if (enable && (next_oh != '0)) begin
            cur_oh   <= next_oh;
            rd_start <= next_oh;
            tcnt     <= '0;
            state    <= ISSUE;
          end else begin
            scan_done <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SSI_SCHED_STATS_EN
  logic       retry_ev, tmo_ev;
  logic [7:0] rbase, tbase;

  always_comb begin
    retry_ev = (state == WAIT_DONE) && sel_done && sel_err && can_retry;
    tmo_ev   = (state == WAIT_DONE) && !sel_done && tmo_hit;
    rbase    = fail_clr ? 8'h00 : retry_cnt;
    tbase    = fail_clr ? 8'h00 : timeout_cnt;
  end

  always_ff @(posedge clk_100m or posedge rst_syn) begin
    if (rst_syn) begin
      retry_cnt   <= 8'h00;
      timeout_cnt <= 8'h00;
    end else begin
      retry_cnt   <= rbase + 8'(retry_ev && (rbase != 8'hFF));
      timeout_cnt <= tbase + 8'(tmo_ev && (tbase != 8'hFF));
    end
  end
`else
  assign retry_cnt   = 8'h00;
  assign timeout_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ssi_read_scheduler.sv
// Directed bench for ssi_read_scheduler: a main instance (TIMEOUT=50) and a long-timeout
// instance (TIMEOUT=200) for the overrun case; a per-channel responder emulates the SSI engines.
module tb_ssi_read_scheduler;
`ifdef SSI_SCHED_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic clk, rst, en, en1, clr, clr1;
  logic [2:0] mask;
  logic [1:0][2:0] done, err, st, fail;
  logic [1:0] busy, sdone, ovr;
  logic [1:0][7:0] rcnt, tcnt;

  int dly[2][3];
  bit errm[2][3];
  int cd[2][3];
  int nst[2][3];
  int nsd[2];
  int onehot_bad;
  logic [2:0] slog0[$];
  int n_cmp, n_err;

  ssi_read_scheduler #(.NUM_CH(3), .READ_PERIOD(100), .TIMEOUT(50), .MAX_RETRY(2)) u_dut (
    .clk_100m(clk), .rst_syn(rst), .enable(en), .ch_mask(mask), .fail_clr(clr),
    .rd_done(done[0]), .rd_crc_err(err[0]), .rd_start(st[0]), .busy(busy[0]),
    .scan_done(sdone[0]), .ch_fail(fail[0]), .overrun(ovr[0]),
    .retry_cnt(rcnt[0]), .timeout_cnt(tcnt[0]));

  ssi_read_scheduler #(.NUM_CH(3), .READ_PERIOD(100), .TIMEOUT(200), .MAX_RETRY(2)) u_dut4 (
    .clk_100m(clk), .rst_syn(rst), .enable(en1), .ch_mask(mask), .fail_clr(clr1),
    .rd_done(done[1]), .rd_crc_err(err[1]), .rd_start(st[1]), .busy(busy[1]),
    .scan_done(sdone[1]), .ch_fail(fail[1]), .overrun(ovr[1]),
    .retry_cnt(rcnt[1]), .timeout_cnt(tcnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder answers dly cycles after the rd_start cycle (dly=0: never); also logs events.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sdone[d]) nsd[d] <= nsd[d] + 1;
      if (st[d] != 3'b000) begin
        if (d == 0) slog0.push_back(st[0]);
        if (!$onehot(st[d])) onehot_bad <= onehot_bad + 1;
      end
      for (int c = 0; c < 3; c++) begin
        if (st[d][c]) nst[d][c] <= nst[d][c] + 1;
        if (rst) begin
          cd[d][c] <= 0; done[d][c] <= 1'b0; err[d][c] <= 1'b0;
        end else if (st[d][c] && dly[d][c] > 0) begin
          cd[d][c] <= dly[d][c]; done[d][c] <= 1'b0; err[d][c] <= 1'b0;
        end else if (cd[d][c] == 1) begin
          cd[d][c] <= 0; done[d][c] <= 1'b1; err[d][c] <= errm[d][c];
        end else begin
          if (cd[d][c] > 1) cd[d][c] <= cd[d][c] - 1;
          done[d][c] <= 1'b0; err[d][c] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_start(input int d, input string tag);
    int n = 0;
    while (st[d] == 3'b000 && n < 300) begin step(1); n++; end
    chk(tag, 32'(st[d] != 3'b000), 1);
  endtask

  task automatic wait_sd(input int d, input string tag);
    int base = nsd[d];
    int n = 0;
    while (nsd[d] == base && n < 400) begin step(1); n++; end
    chk(tag, nsd[d] - base, 1);
  endtask

  initial begin
    int b, sdb, b4;
    n_cmp = 0; n_err = 0; onehot_bad = 0;
    rst = 1'b1; en = 1'b0; en1 = 1'b0; clr = 1'b0; clr1 = 1'b0; mask = 3'b000;
    step(3);
    chk("rst_start", st[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_sdone", sdone[0], 0);
    chk("rst_fail", fail[0], 0);
    chk("rst_ovr", ovr[0], 0);
    chk("rst_rcnt", rcnt[0], 0);
    chk("rst_tcnt", tcnt[0], 0);
    rst = 1'b0;
    step(2);

    // 1: mask 101, clean reads; mid-scan mask change must not affect this scan
    mask = 3'b101; dly[0][0] = 10; dly[0][2] = 10;
    b = slog0.size(); sdb = nsd[0];
    en = 1'b1;
    wait_start(0, "t1_start");
    mask = 3'b010;
    wait_sd(0, "t1_sd");
    en = 1'b0;
    chk("t1_busy", busy[0], 0);
    chk("t1_nstarts", slog0.size() - b, 2);
    chk("t1_first", slog0[b], 3'b001);
    chk("t1_second", slog0[b+1], 3'b100);
    chk("t1_fail", fail[0], 0);
    step(5);
    chk("t1_sd_once", nsd[0] - sdb, 1);

    // 2: ch1 with CRC error on every read
    mask = 3'b010; dly[0][1] = 10; errm[0][1] = 1'b1;
    b = slog0.size();
    en = 1'b1;
    wait_sd(0, "t2_sd");
    en = 1'b0;
    chk("t2_nstarts", slog0.size() - b, 3);
    for (int i = 0; i < 3; i++) chk("t2_start_ch", slog0[b+i], 3'b010);
    chk("t2_rcnt", rcnt[0], STATS * 2);
    chk("t2_fail", fail[0], 3'b010);
    errm[0][1] = 1'b0;
    clr = 1'b1; step(1); clr = 1'b0;
    chk("t2_clr_fail", fail[0], 0);
    chk("t2_clr_rcnt", rcnt[0], 0);

    // 3: ch0 silent, ch2 answers
    mask = 3'b101; dly[0][0] = 0; dly[0][2] = 10;
    en = 1'b1;
    wait_start(0, "t3_start");
    chk("t3_start_ch0", st[0], 3'b001);
    step(49);
    chk("t3_fail_early", fail[0][0], 0);
    step(1);
    chk("t3_fail", fail[0][0], 1);
    chk("t3_tcnt", tcnt[0], STATS);
    step(1);
    chk("t3_ch2_start", st[0], 3'b100);
    wait_sd(0, "t3_sd");
    en = 1'b0;
    chk("t3_fail_final", fail[0], 3'b001);

    // 6: done coincides with the timeout cycle; done wins
    clr = 1'b1; step(1); clr = 1'b0;
    chk("t6_clr_fail", fail[0], 0);
    chk("t6_clr_tcnt", tcnt[0], 0);
    mask = 3'b001; dly[0][0] = 49;
    en = 1'b1;
    wait_sd(0, "t6_sd");
    en = 1'b0;
    chk("t6_fail", fail[0], 0);
    chk("t6_tcnt", tcnt[0], 0);

    // 5: reset during WAIT_DONE
    mask = 3'b001; dly[0][0] = 0;
    en = 1'b1;
    wait_start(0, "t5_start0");
    step(5);
    chk("t5_busy", busy[0], 1);
    rst = 1'b1;
    b = slog0.size();
    step(1);
    chk("t5_rst_start", st[0], 0);
    chk("t5_rst_busy", busy[0], 0);
    chk("t5_rst_sdone", sdone[0], 0);
    chk("t5_rst_fail", fail[0], 0);
    chk("t5_rst_ovr", ovr[0], 0);
    chk("t5_rst_tcnt", tcnt[0], 0);
    step(2);
    chk("t5_no_start_rst", slog0.size() - b, 0);
    rst = 1'b0;
    step(99);
    chk("t5_wait_full", slog0.size() - b, 0);
    step(1);
    chk("t5_start", st[0], 3'b001);
    wait_sd(0, "t5_sd");
    en = 1'b0;

    // 4: long read on the TIMEOUT=200 instance overlaps the next tick
    mask = 3'b001; dly[1][0] = 120;
    en1 = 1'b1;
    wait_start(1, "t4_start");
    b4 = nst[1][0];
    step(100);
    chk("t4_ovr", ovr[1], 1);
    chk("t4_busy", busy[1], 1);
    wait_sd(1, "t4_sd");
    en1 = 1'b0;
    chk("t4_fail", fail[1], 0);
    chk("t4_no_second", nst[1][0] - b4, 0);
    clr1 = 1'b1; step(1); clr1 = 1'b0;
    chk("t4_clr_ovr", ovr[1], 0);

    chk("onehot", onehot_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
